// File: rtl/tone_period_meter_pkg.sv
// Shared types for the tone period meter: FSM states and the FIFO event record.
// The high field exists only when TONE_PERIOD_METER_DUTY_MEASURE_EN is defined.
package tone_meter_pkg;

  localparam int TM_PERIOD_W = 16;

  typedef enum logic [1:0] {IDLE, ARM, LOCK, TONE} tm_state_e;

  typedef struct packed {
    logic [TM_PERIOD_W-1:0] period;
    logic [TM_PERIOD_W-1:0] cycles;
`ifdef TONE_PERIOD_METER_DUTY_MEASURE_EN
    logic [TM_PERIOD_W-1:0] high;
`endif
  } tm_event_t;

endpackage

// File: rtl/tone_period_meter_if.sv
// Event read port: FWFT head of the tone event FIFO with a valid/ready handshake.
interface tone_period_meter_if;
  import tone_meter_pkg::*;

  logic                   evt_valid;
  logic                   evt_ready;
  logic [TM_PERIOD_W-1:0] evt_period;
  logic [TM_PERIOD_W-1:0] evt_cycles;
  logic [TM_PERIOD_W-1:0] evt_high;

  modport master (output evt_valid, evt_period, evt_cycles, evt_high, input evt_ready);
  modport slave  (input evt_valid, evt_period, evt_cycles, evt_high, output evt_ready);
endinterface

// File: rtl/tone_period_meter_fifo.sv
// First-word-fall-through FIFO of tone events (DEPTH a power of two, >= 2).
// A push while full only lands when a pop frees the head in the same cycle.
module tone_event_fifo
  import tone_meter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  tm_event_t din,
  output tm_event_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  tm_event_t     mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          wr_en, rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  // Head is masked while empty so the port reads zero out of reset.
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tone_period_meter.sv
// Tone period meter: measures rising-edge periods of a 1-bit audio pin, locks onto
// stable tones and queues {period, cycles} events. Option: TONE_PERIOD_METER_DUTY_MEASURE_EN.
module tone_period_meter
  import tone_meter_pkg::*;
#(
  parameter int PRESCALE      = 2,
  parameter int PERIOD_W      = TM_PERIOD_W,
  parameter int TOL           = 1,
  parameter int MIN_CYCLES    = 3,
  parameter int SILENCE_TICKS = 4096,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 enable,
  input  logic                 audio_in,
  tone_period_meter_if.master  evt,
  output logic                 locked,
  output logic                 overflow
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int MW   = $clog2(MIN_CYCLES + 1);
  localparam logic [PERIOD_W-1:0] PMAX     = '1;
  localparam logic [PERIOD_W-1:0] SIL_LAST = PERIOD_W'(SILENCE_TICKS - 1);

  logic [PS_W-1:0]     ps_cnt;
  logic                tick;
  logic                sync1, sync2, prev;
  logic                rise, rise_q, sil_q;
  logic [PERIOD_W-1:0] per_cnt, meas, meas_inc;

  tm_state_e           state_q, state_d;
  logic [PERIOD_W-1:0] cand_q, cand_d, cycles_q, cycles_d;
  logic [MW-1:0]       match_q, match_d;
  logic [PERIOD_W:0]   diff, adiff;
  logic                same, push, pop, full, empty;
  tm_event_t           ev_in, ev_head;

  assign tick     = (ps_cnt == PS_W'(PRESCALE - 1));
  assign rise     = tick & sync2 & ~prev;
  assign meas_inc = (per_cnt == PMAX) ? PMAX : per_cnt + PERIOD_W'(1);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ps_cnt  <= '0;
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      prev    <= 1'b0;
      per_cnt <= '0;
      meas    <= '0;
      rise_q  <= 1'b0;
      sil_q   <= 1'b0;
    end else begin
      ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
      sync1  <= audio_in;
      sync2  <= sync1;
      if (tick) prev <= sync2;
      // Decisions are registered so the FSM sees meas one clock after the rise tick.
      rise_q <= enable & rise;
      sil_q  <= enable & tick & ~rise & (per_cnt == SIL_LAST);
      if (!enable)
        per_cnt <= '0;
      else if (rise) begin
        per_cnt <= '0;
        meas    <= meas_inc;
      end else if (tick && per_cnt != PMAX)
        per_cnt <= per_cnt + PERIOD_W'(1);
    end
  end

  // A saturated measurement means "too long to know", so it only matches a saturated candidate.
  assign diff  = {1'b0, meas} - {1'b0, cand_q};
  assign adiff = diff[PERIOD_W] ? -diff : diff;
  assign same  = (adiff <= (PERIOD_W+1)'(TOL)) && !(meas == PMAX && cand_q != PMAX);

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    match_d  = match_q;
    cycles_d = cycles_q;
    push     = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (rise_q) state_d = ARM;
        ARM: begin
          if (sil_q) state_d = IDLE;
          else if (rise_q) begin
            state_d = LOCK;
            cand_d  = meas;
            match_d = MW'(1);
          end
        end
        LOCK: begin
          if (sil_q) state_d = IDLE;
          else if (rise_q) begin
            if (same) begin
              if (match_q == MW'(MIN_CYCLES - 1)) begin
                state_d  = TONE;
                cycles_d = PERIOD_W'(MIN_CYCLES);
              end else
                match_d = match_q + MW'(1);
            end else begin
              cand_d  = meas;
              match_d = MW'(1);
            end
          end
        end
        TONE: begin
          if (sil_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else if (rise_q) begin
            if (same) begin
              if (cycles_q != PMAX) cycles_d = cycles_q + PERIOD_W'(1);
            end else begin
              push    = 1'b1;
              cand_d  = meas;
              match_d = MW'(1);
              state_d = LOCK;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      match_q  <= '0;
      cycles_q <= '0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      match_q  <= match_d;
      cycles_q <= cycles_d;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign locked = (state_q == TONE);

`ifdef TONE_PERIOD_METER_DUTY_MEASURE_EN
  logic                fall;
  logic [PERIOD_W-1:0] hi_cnt, hi_lat;

  assign fall = tick & ~sync2 & prev;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      hi_cnt <= '0;
      hi_lat <= '0;
    end else begin
      if (rise) hi_cnt <= '0;
      else if (tick && hi_cnt != PMAX) hi_cnt <= hi_cnt + PERIOD_W'(1);
      if (fall) hi_lat <= (hi_cnt == PMAX) ? PMAX : hi_cnt + PERIOD_W'(1);
    end
  end
`endif

  always_comb begin
    ev_in        = '0;
    ev_in.period = TM_PERIOD_W'(cand_q);
    ev_in.cycles = TM_PERIOD_W'(cycles_q);
`ifdef TONE_PERIOD_METER_DUTY_MEASURE_EN
    ev_in.high   = TM_PERIOD_W'(hi_lat);
`endif
  end

  assign pop = evt.evt_ready & ~empty;

  tone_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .pop   (pop),
    .din   (ev_in),
    .dout  (ev_head),
    .full  (full),
    .empty (empty)
  );

  assign evt.evt_valid  = ~empty;
  assign evt.evt_period = ev_head.period;
  assign evt.evt_cycles = ev_head.cycles;
`ifdef TONE_PERIOD_METER_DUTY_MEASURE_EN
  assign evt.evt_high   = ev_head.high;
`else
  assign evt.evt_high   = '0;
`endif

endmodule

// File: tb/tb_tone_period_meter.sv
// Directed bench for tone_period_meter: tone table plus hand sequences for tone change,
// non-locking jitter, enable/reset mid-tone and FIFO overflow. Silence is shortened to 1024 ticks.
module tb_tone_period_meter;
  import tone_meter_pkg::*;

  localparam int SIL_TICKS = 1024;
  localparam int SIL_WAIT  = 2300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic audio = 1'b0;
  logic locked, overflow;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0, saw_lock = 1'b0, saw_valid = 1'b0;

  tone_period_meter_if ev_if ();

  always #5 clk = ~clk;

  tone_period_meter #(
    .PRESCALE(2), .PERIOD_W(16), .TOL(1), .MIN_CYCLES(3),
    .SILENCE_TICKS(SIL_TICKS), .FIFO_DEPTH(4)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .enable   (enable),
    .audio_in (audio),
    .evt      (ev_if),
    .locked   (locked),
    .overflow (overflow)
  );

  always @(negedge clk) begin
    if (mon_en) begin
      if (locked) saw_lock <= 1'b1;
      if (ev_if.evt_valid) saw_valid <= 1'b1;
    end
  end

  typedef struct {
    int hi;
    int lo;
    int n;
    bit exp_valid;
    int exp_period;
    int exp_cycles;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      audio = 1'b1;
      clks(hi);
      audio = 1'b0;
      clks(lo);
    end
  endtask

  task automatic pop();
    ev_if.evt_ready = 1'b1;
    clks(1);
    ev_if.evt_ready = 1'b0;
  endtask

  // hlo/hhi: accepted high-time range in ticks, only meaningful with duty measurement.
  task automatic check_head(input string tag, input int per, input int cyc, input int hlo, input int hhi);
    check({tag, " valid"}, {31'd0, ev_if.evt_valid}, 1);
    check({tag, " period"}, {16'd0, ev_if.evt_period}, per);
    check({tag, " cycles"}, {16'd0, ev_if.evt_cycles}, cyc);
`ifdef TONE_PERIOD_METER_DUTY_MEASURE_EN
    check({tag, " high in range"},
          {31'd0, (int'(ev_if.evt_high) >= hlo) && (int'(ev_if.evt_high) <= hhi)}, 1);
`else
    check({tag, " high tied"}, {16'd0, ev_if.evt_high}, 0);
    if (hlo > hhi) $display("note: bad high range for %s", tag);
`endif
    pop();
  endtask

  initial begin
    ev_if.evt_ready = 1'b0;
    vecs[0] = '{30, 30, 9, 1'b1, 30, 8};
    vecs[1] = '{20, 20, 4, 1'b1, 20, 3};
    vecs[2] = '{20, 20, 3, 1'b0, 0, 0};
    vecs[3] = '{25, 75, 13, 1'b1, 50, 12};
    vecs[4] = '{40, 60, 5, 1'b1, 50, 4};

    clks(4);
    check("reset evt_valid", {31'd0, ev_if.evt_valid}, 0);
    check("reset locked", {31'd0, locked}, 0);
    check("reset overflow", {31'd0, overflow}, 0);
    check("reset period", {16'd0, ev_if.evt_period}, 0);
    check("reset cycles", {16'd0, ev_if.evt_cycles}, 0);
    check("reset high", {16'd0, ev_if.evt_high}, 0);
    rst = 1'b0;
    enable = 1'b1;
    clks(4);

    // 12 periods of 100 clocks: lock appears on the 4th rise, event after silence
    pulses(3, 50, 50);
    check("t1 unlocked after 2 periods", {31'd0, locked}, 0);
    audio = 1'b1;
    clks(20);
    check("t1 locked at 4th rise", {31'd0, locked}, 1);
    clks(30);
    audio = 1'b0;
    clks(50);
    pulses(9, 50, 50);
    clks(1880);
    check("t1 locked before silence", {31'd0, locked}, 1);
    check("t1 no event before silence", {31'd0, ev_if.evt_valid}, 0);
    clks(320);
    check("t1 unlocked after silence", {31'd0, locked}, 0);
    check_head("t1", 50, 12, 25, 25);

    for (int v = 0; v < 5; v++) begin
      pulses(vecs[v].n, vecs[v].hi, vecs[v].lo);
      clks(SIL_WAIT);
      check($sformatf("vec%0d locked", v), {31'd0, locked}, 0);
      if (vecs[v].exp_valid)
        check_head($sformatf("vec%0d", v), vecs[v].exp_period, vecs[v].exp_cycles,
                   vecs[v].hi / 2, (vecs[v].hi + 1) / 2);
      check($sformatf("vec%0d drained", v), {31'd0, ev_if.evt_valid}, 0);
    end

    // tone change: 6 periods of 100 then 8 of 60; the first event's high comes from a 30-clock pulse
    pulses(6, 50, 50);
    pulses(9, 30, 30);
    clks(SIL_WAIT);
    check_head("t2 first", 50, 6, 15, 15);
    check_head("t2 second", 30, 8, 15, 15);
    check("t2 drained", {31'd0, ev_if.evt_valid}, 0);

    // 50/52-tick alternation exceeds TOL every time
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pulses(1, 50, 50);
      pulses(1, 52, 52);
    end
    clks(SIL_WAIT);
    mon_en = 1'b0;
    clks(1);
    check("t3 never locked", {31'd0, saw_lock}, 0);
    check("t3 never valid", {31'd0, saw_valid}, 0);

    // enable pulse mid-tone discards it; relock counts only later periods
    pulses(6, 50, 50);
    check("t5e locked before pulse", {31'd0, locked}, 1);
    enable = 1'b0;
    clks(3);
    check("t5e idle while disabled", {31'd0, locked}, 0);
    enable = 1'b1;
    pulses(5, 50, 50);
    clks(SIL_WAIT);
    check_head("t5e relock", 50, 4, 25, 25);
    check("t5e single event", {31'd0, ev_if.evt_valid}, 0);

    // five tones with no consumer: fifth is dropped, overflow sticks
    for (int t = 0; t < 5; t++) begin
      pulses(5, 5 + t, 5 + t);
      clks(SIL_WAIT);
      if (t == 3) check("t4 no overflow at 4", {31'd0, overflow}, 0);
    end
    check("t4 overflow", {31'd0, overflow}, 1);
    for (int t = 0; t < 4; t++)
      check_head($sformatf("t4 ev%0d", t), 5 + t, 4, (5 + t) / 2, (6 + t) / 2);
    check("t4 drained", {31'd0, ev_if.evt_valid}, 0);
    pop();
    check("t4 pop empty ignored", {31'd0, ev_if.evt_valid}, 0);
    check("t4 overflow sticky", {31'd0, overflow}, 1);

    // reset mid-tone clears everything; relock yields a fresh event
    pulses(6, 50, 50);
    rst = 1'b1;
    clks(2);
    check("t5r valid after reset", {31'd0, ev_if.evt_valid}, 0);
    check("t5r overflow after reset", {31'd0, overflow}, 0);
    check("t5r locked after reset", {31'd0, locked}, 0);
    rst = 1'b0;
    pulses(5, 50, 50);
    clks(SIL_WAIT);
    check_head("t5r relock", 50, 4, 25, 25);
    check("t5r single event", {31'd0, ev_if.evt_valid}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
